// File: rtl/reg_file_mp.sv
// Purpose: parametrised multi-port register file for the decode stage: two write
//          ports with write-through bypass, NUM_RD combinational read ports plus a
//          debug peek port, a per-register pending scoreboard and a post-reset
//          clear sequence that zeroes every stored register.
// Ports:   CLK/RESET (sync, active-high); WE_A/WA_A/WD_A (ALU write-back);
//          WE_B/WA_B/WD_B (load return); RA/RD packed read ports; R15 supplies the
//          PC index value; set_pend/set_idx/pend scoreboard; clr_busy while
//          clearing; peek_sel/peek_data debug read.
// Latency: reads are combinational; writes land in the array on the next edge.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 3,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WE_A,
  input  logic [AW-1:0]            WA_A,
  input  logic [DATA_W-1:0]        WD_A,
  input  logic                     WE_B,
  input  logic [AW-1:0]            WA_B,
  input  logic [DATA_W-1:0]        WD_B,
  input  logic [NUM_RD*AW-1:0]     RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  input  logic [DATA_W-1:0]        R15,
  input  logic                     set_pend,
  input  logic [AW-1:0]            set_idx,
  output logic [NUM_REGS-1:0]      pend,
  output logic                     clr_busy,
  input  logic [AW-1:0]            peek_sel,
  output logic [DATA_W-1:0]        peek_data
);

  // The top index is the PC: it has no storage and always reads R15.
  localparam logic [AW-1:0] PC_IDX   = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 2);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     ctr, ctr_nxt;
  logic [DATA_W-1:0] rf [NUM_REGS-1];
  logic [NUM_REGS-1:0] pend_nxt;
  logic              wr_a, wr_b;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= CLEAR;
      ctr   <= '0;
    end else begin
      state <= state_nxt;
      ctr   <= ctr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    case (state)
      CLEAR: begin
        ctr_nxt = ctr + 1'b1;
        if (ctr == LAST_IDX) begin
          state_nxt = IDLE;
          ctr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign clr_busy = (state == CLEAR);

  // Writes only take effect in IDLE and never to the PC index.
  assign wr_a = (state == IDLE) && WE_A && (WA_A != PC_IDX);
  assign wr_b = (state == IDLE) && WE_B && (WA_B != PC_IDX);

  // ---------------- storage ----------------
  // Port B is applied first so port A overrides it on an index collision.
  always_ff @(posedge CLK) begin
    if (state == CLEAR) begin
      rf[ctr] <= '0;
    end else begin
      if (wr_b) rf[WA_B] <= WD_B;
      if (wr_a) rf[WA_A] <= WD_A;
    end
  end

  // ---------------- read path ----------------
  function automatic logic [DATA_W-1:0] rd_mux(input logic [AW-1:0] idx);
    logic [DATA_W-1:0] v;
    if (idx == PC_IDX)                v = R15;
    else if (state == CLEAR)          v = '0;
    else if (WE_A && (WA_A == idx))   v = WD_A;
    else if (WE_B && (WA_B == idx))   v = WD_B;
    else                              v = rf[idx];
    return v;
  endfunction

  always_comb begin
    RD = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      RD[i*DATA_W +: DATA_W] = rd_mux(RA[i*AW +: AW]);
    end
    peek_data = rd_mux(peek_sel);
  end

  // ---------------- pending scoreboard ----------------
  // Clears are applied before the set so a same-cycle set wins. The PC bit is
  // never set and resets to 0, so it stays constant.
  always_comb begin
    pend_nxt = pend;
    if (state == IDLE) begin
      if (wr_a) pend_nxt[WA_A] = 1'b0;
      if (wr_b) pend_nxt[WA_B] = 1'b0;
      if (set_pend && (set_idx != PC_IDX)) pend_nxt[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) pend <= '0;
    else       pend <= pend_nxt;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Purpose: directed self-checking bench for reg_file_mp with a queue of expected
//          values filled as stimulus is driven and drained when outputs are sampled.
// Ports:   none (top-level bench).
module tb_reg_file_mp;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int NUM_RD   = 3;
  localparam int AW       = 4;

  logic                     CLK = 1'b0;
  logic                     RESET;
  logic                     WE_A, WE_B;
  logic [AW-1:0]            WA_A, WA_B;
  logic [DATA_W-1:0]        WD_A, WD_B;
  logic [NUM_RD*AW-1:0]     RA;
  logic [NUM_RD*DATA_W-1:0] RD;
  logic [DATA_W-1:0]        R15;
  logic                     set_pend;
  logic [AW-1:0]            set_idx;
  logic [NUM_REGS-1:0]      pend;
  logic                     clr_busy;
  logic [AW-1:0]            peek_sel;
  logic [DATA_W-1:0]        peek_data;

  reg_file_mp #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) dut (
    .CLK(CLK), .RESET(RESET),
    .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
    .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
    .RA(RA), .RD(RD), .R15(R15),
    .set_pend(set_pend), .set_idx(set_idx), .pend(pend),
    .clr_busy(clr_busy), .peek_sel(peek_sel), .peek_data(peek_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL sb_underflow observed=%h expected=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic [63:0] rd(input int i);
    return {32'h0, RD[i*DATA_W +: DATA_W]};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    RA = {a2, a1, a0};
  endtask

  // Expect/observe the three read ports in port order.
  task automatic exp_rd(input string t, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    push({t, "_rd0"}, {32'h0, e0});
    push({t, "_rd1"}, {32'h0, e1});
    push({t, "_rd2"}, {32'h0, e2});
  endtask

  task automatic obs_rd();
    chk(rd(0));
    chk(rd(1));
    chk(rd(2));
  endtask

  initial begin
    RESET = 1'b1;
    WE_A = 1'b0; WA_A = '0; WD_A = '0;
    WE_B = 1'b0; WA_B = '0; WD_B = '0;
    RA = '0; R15 = 32'h0000_0108;
    set_pend = 1'b0; set_idx = '0; peek_sel = '0;

    // Reset state after first edge with RESET high.
    cyc();
    push("rst_busy", 64'd1);
    push("rst_pend", 64'd0);
    #4; chk({63'h0, clr_busy}); chk({48'h0, pend});

    // Second reset edge, then deassert: clear runs for 15 cycles.
    cyc();
    RESET = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) cyc();
      WE_A = 1'b1; WA_A = 4'd3; WD_A = 32'hDEAD;
      set_ra(4'd3, 4'd5, 4'd15);
      R15 = 32'h100 + i;
      peek_sel = 4'd3;
      push("clr_busy", 64'd1);
      exp_rd("clr", 32'h0, 32'h0, 32'h100 + i);
      push("clr_peek", 64'd0);
      #4; chk({63'h0, clr_busy}); obs_rd(); chk({32'h0, peek_data});
    end
    cyc();
    WE_A = 1'b0;
    set_ra(4'd3, 4'd0, 4'd14);
    push("clr_done", 64'd0);
    exp_rd("post_clr", 32'h0, 32'h0, 32'h0);
    #4; chk({63'h0, clr_busy}); obs_rd();

    // Bypass on port A, then stored value.
    cyc();
    WE_A = 1'b1; WA_A = 4'd5; WD_A = 32'h1111_1111;
    set_ra(4'd5, 4'd3, 4'd0);
    push("byp_same", 64'h1111_1111);
    #4; chk(rd(0));
    cyc();
    WE_A = 1'b0;
    push("byp_next", 64'h1111_1111);
    #4; chk(rd(0));

    // Port conflict: A wins; parallel B write to another index.
    cyc();
    WE_A = 1'b1; WA_A = 4'd7; WD_A = 32'hA;
    WE_B = 1'b1; WA_B = 4'd7; WD_B = 32'hB;
    set_ra(4'd7, 4'd3, 4'd5);
    exp_rd("conf_same", 32'hA, 32'h0, 32'h1111_1111);
    #4; obs_rd();
    cyc();
    WE_A = 1'b1; WA_A = 4'd9; WD_A = 32'h9;
    WE_B = 1'b1; WA_B = 4'd8; WD_B = 32'hB;
    set_ra(4'd7, 4'd8, 4'd9);
    exp_rd("dual_byp", 32'hA, 32'hB, 32'h9);
    #4; obs_rd();
    cyc();
    WE_A = 1'b0; WE_B = 1'b0;
    peek_sel = 4'd8;
    exp_rd("dual_store", 32'hA, 32'hB, 32'h9);
    push("peek_r8", 64'hB);
    #4; obs_rd(); chk({32'h0, peek_data});

    // PC index reads R15; writes to it are dropped.
    cyc();
    set_ra(4'd15, 4'd15, 4'd15);
    peek_sel = 4'd15;
    R15 = 32'h0000_0108;
    WE_A = 1'b1; WA_A = 4'd15; WD_A = 32'hFFFF;
    exp_rd("pc", 32'h108, 32'h108, 32'h108);
    push("pc_peek", 64'h108);
    #4; obs_rd(); chk({32'h0, peek_data});
    cyc();
    WE_A = 1'b0;
    R15 = 32'h0000_010C;
    exp_rd("pc_after_wr", 32'h10C, 32'h10C, 32'h10C);
    push("pc_pend", 64'd0);
    #4; obs_rd(); chk({48'h0, pend});

    // Scoreboard: set, clear by port B, set-wins, PC bit stays 0.
    cyc();
    set_pend = 1'b1; set_idx = 4'd4;
    push("pend_same_cyc", 64'd0);
    #4; chk({48'h0, pend});
    cyc();
    set_pend = 1'b0;
    push("pend_set", 64'h0010);
    #4; chk({48'h0, pend});
    cyc();
    WE_B = 1'b1; WA_B = 4'd4; WD_B = 32'h44;
    push("pend_pre_clr", 64'h0010);
    #4; chk({48'h0, pend});
    cyc();
    WE_B = 1'b0;
    push("pend_clr_b", 64'h0000);
    #4; chk({48'h0, pend});
    cyc();
    set_pend = 1'b1; set_idx = 4'd4;
    WE_A = 1'b1; WA_A = 4'd4; WD_A = 32'h55;
    cyc();
    WE_A = 1'b0;
    set_idx = 4'd15;
    push("pend_set_wins", 64'h0010);
    #4; chk({48'h0, pend});
    cyc();
    set_pend = 1'b0;
    push("pend_pc_const", 64'h0010);
    #4; chk({48'h0, pend});

    // Reset mid-clear restarts the sequence; pend stays 0, set_pend ignored.
    cyc();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      set_pend = 1'b1; set_idx = 4'd2;
      push("mid_busy", 64'd1);
      push("mid_pend", 64'd0);
      #4; chk({63'h0, clr_busy}); chk({48'h0, pend});
    end
    cyc();
    RESET = 1'b1;
    push("mid_busy_ctr6", 64'd1);
    #4; chk({63'h0, clr_busy});
    cyc();
    RESET = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) cyc();
      push("restart_busy", 64'd1);
      push("restart_pend", 64'd0);
      #4; chk({63'h0, clr_busy}); chk({48'h0, pend});
    end
    cyc();
    set_pend = 1'b0;
    set_ra(4'd5, 4'd7, 4'd8);
    push("restart_done", 64'd0);
    push("restart_pend_end", 64'd0);
    exp_rd("restart_zero", 32'h0, 32'h0, 32'h0);
    #4; chk({63'h0, clr_busy}); chk({48'h0, pend}); obs_rd();

    // Every pushed expectation must have been consumed.
    n_cmp++;
    assert (sbq.size() === 0) else begin
      n_err++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
